// File: rtl/arbiter_pkg.sv
// Shared helpers for the dynamic-priority round-robin arbiter.
// Priority encoding: lower value = more urgent, 0 = most urgent.
// Helpers work on int unsigned so they serve any priority width. Callers cast the
// result back to their own width.
package arbiter_pkg;

  // Width of a counter that must hold values 0..age_period.
  function automatic int unsigned calc_cw(int unsigned age_period);
    return $clog2(age_period + 1);
  endfunction

  // Saturating decrement: 0 stays 0.
  function automatic int unsigned sat_dec(int unsigned x);
    return (x == 0) ? 0 : x - 1;
  endfunction

  // Numerically smaller (more urgent) of two priorities.
  function automatic int unsigned min_prt(int unsigned a, int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/priority_aging_cell.sv
// One requester's aging state: registered priority plus the age counter.
// Optional feature macro: PRIORITY_AGING_STARVE_MON_EN adds a registered starved flag.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   clk_en       state advances only when high
//   req_i        this requester is asking
//   grant_hit_i  arbiter granted this requester this cycle (valid already folded in)
//   base_i       static base priority
//   prt_o        registered aged priority
//   starved_o    (feature only) promotion attempted while already at priority 0
module priority_aging_cell
  import arbiter_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned LN         = 2,
  parameter int unsigned AGE_PERIOD = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic          req_i,
  input  logic          grant_hit_i,
  input  logic [LN-1:0] base_i,
`ifdef PRIORITY_AGING_STARVE_MON_EN
  output logic          starved_o,
`endif
  output logic [LN-1:0] prt_o
);

  localparam int unsigned CW = calc_cw(AGE_PERIOD);
  localparam logic [LN-1:0] RstPrt = LN'(N - 1);
  localparam logic [CW-1:0] LastCnt = CW'(AGE_PERIOD - 1);

  logic [LN-1:0] prt_q, prt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          promote;

  // A waiting requester that has finished a full aging window this edge.
  assign promote = req_i && !grant_hit_i && (cnt_q == LastCnt);

  always_comb begin
    prt_d = prt_q;
    cnt_d = cnt_q;
    if (grant_hit_i || !req_i) begin
      // A grant beats a same-cycle promotion; idle also reloads.
      prt_d = base_i;
      cnt_d = '0;
    end else if (promote) begin
      prt_d = LN'(min_prt(sat_dec(32'(prt_q)), 32'(base_i)));
      cnt_d = '0;
    end else begin
      // The min lets a base made more urgent mid-wait take effect at once, while
      // a base made less urgent never demotes an already aged requester.
      prt_d = LN'(min_prt(32'(prt_q), 32'(base_i)));
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prt_q <= RstPrt;
      cnt_q <= '0;
    end else if (clk_en) begin
      prt_q <= prt_d;
      cnt_q <= cnt_d;
    end
  end

  assign prt_o = prt_q;

`ifdef PRIORITY_AGING_STARVE_MON_EN
  logic starved_q, starved_d;

  always_comb begin
    starved_d = starved_q;
    if (grant_hit_i || !req_i) begin
      starved_d = 1'b0;
    end else if (promote && (prt_q == '0)) begin
      starved_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starved_q <= 1'b0;
    end else if (clk_en) begin
      starved_q <= starved_d;
    end
  end

  assign starved_o = starved_q;
`endif

endmodule

// File: rtl/priority_aging_unit.sv
// Priority aging stage ahead of the dynamic-priority round-robin arbiter. Turns
// static base priorities into registered aged priorities so that long-waiting
// requesters are promoted one step every AGE_PERIOD enabled waiting cycles.
// Optional feature macro: PRIORITY_AGING_STARVE_MON_EN (adds the starved output).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clk_en     state advances only when high
//   req        request vector (same one the arbiter sees)
//   base_prt   per-requester base priority
//   grant      arbiter grant index, qualified by valid
//   valid      arbiter grant valid
//   prt        registered aged priority to the arbiter
//   starved    (feature only) per-requester starvation flag
module priority_aging_unit
  import arbiter_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned LN         = $clog2(N),
  parameter int unsigned AGE_PERIOD = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic [N-1:0]  req,
  input  logic [LN-1:0] base_prt [N-1:0],
  input  logic [LN-1:0] grant,
  input  logic          valid,
`ifdef PRIORITY_AGING_STARVE_MON_EN
  output logic [N-1:0]  starved,
`endif
  output logic [LN-1:0] prt      [N-1:0]
);

  logic [N-1:0] grant_hit;

  for (genvar i = 0; i < N; i++) begin : g_cell
    // Indices >= N never compare equal, so an out-of-range grant hits nobody.
    assign grant_hit[i] = valid && (grant == LN'(i));

    priority_aging_cell #(
      .N          (N),
      .LN         (LN),
      .AGE_PERIOD (AGE_PERIOD)
    ) u_cell (
      .clk         (clk),
      .rst         (rst),
      .clk_en      (clk_en),
      .req_i       (req[i]),
      .grant_hit_i (grant_hit[i]),
      .base_i      (base_prt[i]),
`ifdef PRIORITY_AGING_STARVE_MON_EN
      .starved_o   (starved[i]),
`endif
      .prt_o       (prt[i])
    );
  end

endmodule

// File: tb/tb_priority_aging_unit.sv
// Directed bench for priority_aging_unit with N=4, AGE_PERIOD=4.
module tb_priority_aging_unit;

  localparam int unsigned N  = 4;
  localparam int unsigned LN = 2;
  localparam int unsigned AP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_en;
  logic [N-1:0]  req;
  logic [LN-1:0] base_prt [N-1:0];
  logic [LN-1:0] grant;
  logic          valid;
  logic [LN-1:0] prt      [N-1:0];
`ifdef PRIORITY_AGING_STARVE_MON_EN
  logic [N-1:0]  starved;
`endif

  int total = 0;
  int bad   = 0;

  priority_aging_unit #(
    .N          (N),
    .LN         (LN),
    .AGE_PERIOD (AP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .req      (req),
    .base_prt (base_prt),
    .grant    (grant),
    .valid    (valid),
`ifdef PRIORITY_AGING_STARVE_MON_EN
    .starved  (starved),
`endif
    .prt      (prt)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, int obs, int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then sample 1 time unit later.
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b1;
    clk_en = 1'b1;
    req    = '0;
    grant  = '0;
    valid  = 1'b0;
    for (int i = 0; i < N; i++) base_prt[i] = LN'(i);

    // Reset: all priorities to N-1.
    tick(2);
    for (int i = 0; i < N; i++) check($sformatf("rst_prt%0d", i), int'(prt[i]), 3);
`ifdef PRIORITY_AGING_STARVE_MON_EN
    check("rst_starved", int'(starved), 0);
`endif

    // Release with req=0: bases load.
    rst = 1'b0;
    tick(1);
    for (int i = 0; i < N; i++) check($sformatf("load_prt%0d", i), int'(prt[i]), i);

    // Aging of requester 2 from base 3, never granted.
    base_prt[2] = 2'd3;
    tick(1);
    check("age_load", int'(prt[2]), 3);
    req = 4'b0100;
    tick(3);
    check("age_e3", int'(prt[2]), 3);
    tick(1);
    check("age_e4", int'(prt[2]), 2);
    tick(4);
    check("age_e8", int'(prt[2]), 1);
    tick(4);
    check("age_e12", int'(prt[2]), 0);
    tick(3);
`ifdef PRIORITY_AGING_STARVE_MON_EN
    check("starve_e15", int'(starved[2]), 0);
`endif
    tick(1);
    check("age_e16_sat", int'(prt[2]), 0);
`ifdef PRIORITY_AGING_STARVE_MON_EN
    check("starve_e16", int'(starved[2]), 1);
`endif
    tick(4);
    check("age_e20_sat", int'(prt[2]), 0);
    // Idle requester 0 meanwhile just tracks its base.
    check("idle_prt0", int'(prt[0]), 0);
    // Grant to 2 clears starvation and reloads base.
    valid = 1'b1;
    grant = 2'd2;
    tick(1);
    check("grant2_reload", int'(prt[2]), 3);
`ifdef PRIORITY_AGING_STARVE_MON_EN
    check("starve_clr", int'(starved[2]), 0);
`endif

    // Grant beats promotion on requester 1, base 3. Grant index 1 is present
    // with valid=0 during the wait and must be ignored.
    valid = 1'b0;
    grant = 2'd1;
    req   = '0;
    base_prt[1] = 2'd3;
    tick(1);
    req = 4'b0010;
    tick(4);
    check("gbp_aged", int'(prt[1]), 2);
    tick(3);
    check("gbp_cnt3", int'(prt[1]), 2);
    valid = 1'b1;
    tick(1);
    check("gbp_grant", int'(prt[1]), 3);
    valid = 1'b0;
    tick(1);
    check("gbp_cnt_cleared", int'(prt[1]), 3);

    // Idle reload of requester 0, base 2.
    req = '0;
    base_prt[0] = 2'd2;
    tick(1);
    req = 4'b0001;
    tick(8);
    check("idle_aged0", int'(prt[0]), 0);
    req = '0;
    tick(1);
    check("idle_reload0", int'(prt[0]), 2);

    // clk_en hold: counter at 2, then 5 frozen edges with inputs that would
    // otherwise reload, grant and reset the counter.
    req = 4'b0001;
    tick(2);
    clk_en = 1'b0;
    req    = '0;
    valid  = 1'b1;
    grant  = 2'd0;
    tick(5);
    check("hold_prt0", int'(prt[0]), 2);
    check("hold_prt1", int'(prt[1]), 3);
    clk_en = 1'b1;
    req    = 4'b0001;
    valid  = 1'b0;
    tick(1);
    check("hold_cnt3", int'(prt[0]), 2);
    tick(1);
    check("hold_promote", int'(prt[0]), 1);

    // Base change mid-wait on requester 3.
    req = '0;
    tick(1);
    check("base_load3", int'(prt[3]), 3);
    req = 4'b1000;
    tick(4);
    check("base_aged3", int'(prt[3]), 2);
    base_prt[3] = 2'd1;
    tick(1);
    check("base_urgent", int'(prt[3]), 1);
    base_prt[3] = 2'd3;
    tick(1);
    check("base_lax", int'(prt[3]), 1);

    // Reset wins even with clk_en low.
    rst    = 1'b1;
    clk_en = 1'b0;
    tick(1);
    check("rst_noen3", int'(prt[3]), 3);
    check("rst_noen0", int'(prt[0]), 3);
    rst    = 1'b0;
    clk_en = 1'b1;
    req    = '0;
    tick(1);
    check("post_rst0", int'(prt[0]), 2);
    check("post_rst3", int'(prt[3]), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
